pop_topk_selector: RTL and testbench



---
 rtl/pop_topk_selector.sv | 154 +++++++++++++++
 tb/tb_pop_topk_selector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pop_topk_selector.sv
// Streaming top-K selector: keeps the best K individuals in a sorted register list while
// a population streams in, then emits them in rank order over a valid/ready stream.
module pop_topk_selector #(
   parameter int GENE_W   = 150,
   parameter int FIT_W    = 16,
   parameter int K        = 10,
   parameter int IDX_W    = 8,
   parameter bit MAXIMIZE = 1'b0,
   localparam int RANK_W  = $clog2(K + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [GENE_W-1:0] in_gene,
   input  logic [FIT_W-1:0]  in_fit,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [GENE_W-1:0] out_gene,
   output logic [FIT_W-1:0]  out_fit,
   output logic [IDX_W-1:0]  out_idx,
   output logic [RANK_W-1:0] out_rank,
   output logic              out_last,
   output logic              done
);

   localparam int RSEL_W = (K > 1) ? $clog2(K) : 1;
   localparam logic [RANK_W-1:0] K_R = RANK_W'(K);

   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_EMIT} state_t;

   state_t             state_q, state_d;
   logic [RANK_W-1:0]  fill_q, fill_d;
   logic [RANK_W-1:0]  r_q, r_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;

   logic [GENE_W-1:0]  gene_q [K];
   logic [FIT_W-1:0]   fit_q  [K];
   logic [IDX_W-1:0]   idx_q  [K];

   logic [K-1:0]       ge;
   logic               accept;
   logic               emit;
   logic               last_ent;
   logic [RSEL_W-1:0]  rsel;

   assign accept   = (state_q == S_COLLECT) && in_valid;
   assign emit     = (state_q == S_EMIT);
   assign last_ent = (r_q == fill_q - 1'b1);

   // The list is kept sorted, so ge[] is a prefix of ones; the first zero is the insert slot.
   // Using >=/<= keeps an earlier equal score ahead of the newcomer.
   for (genvar i = 0; i < K; i++) begin : g_slot
      assign ge[i] = (i < int'(fill_q)) &&
                     (MAXIMIZE ? (fit_q[i] >= in_fit) : (fit_q[i] <= in_fit));

      if (i == 0) begin : g_head
         always_ff @(posedge clk) begin
            if (accept && !ge[0]) begin
               gene_q[0] <= in_gene;
               fit_q[0]  <= in_fit;
               idx_q[0]  <= cnt_q;
            end
         end
      end else begin : g_body
         always_ff @(posedge clk) begin
            if (accept && !ge[i]) begin
               if (ge[i-1]) begin
                  gene_q[i] <= in_gene;
                  fit_q[i]  <= in_fit;
                  idx_q[i]  <= cnt_q;
               end else begin
                  gene_q[i] <= gene_q[i-1];
                  fit_q[i]  <= fit_q[i-1];
                  idx_q[i]  <= idx_q[i-1];
               end
            end
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      fill_d    = fill_q;
      r_d       = r_q;
      cnt_d     = cnt_q;
      done_d    = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               fill_d  = '0;
               cnt_d   = '0;
               r_d     = '0;
               state_d = S_COLLECT;
            end
         end
         S_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cnt_d  = cnt_q + 1'b1;
               fill_d = (fill_q == K_R) ? fill_q : fill_q + 1'b1;
               if (in_last) begin
                  r_d     = '0;
                  state_d = S_EMIT;
               end
            end
         end
         S_EMIT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               if (last_ent) begin
                  r_d     = '0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  r_d = r_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         fill_q  <= '0;
         r_q     <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Outputs are forced to zero outside EMIT so a reset clears them without a clock.
   assign rsel     = r_q[RSEL_W-1:0];
   assign out_gene = emit ? gene_q[rsel] : '0;
   assign out_fit  = emit ? fit_q[rsel]  : '0;
   assign out_idx  = emit ? idx_q[rsel]  : '0;
   assign out_rank = emit ? r_q          : '0;
   assign out_last = emit && last_ent;
   assign done     = done_q;

endmodule

// File: tb/tb_pop_topk_selector.sv
// Directed bench for pop_topk_selector: minimise and maximise instances share one stimulus stream.
module tb_pop_topk_selector;

   localparam int GENE_W = 8;
   localparam int FIT_W  = 8;
   localparam int K      = 4;
   localparam int IDX_W  = 4;
   localparam int RW     = $clog2(K + 1);

   logic clk = 1'b0;
   logic rst_n, start, in_valid, in_last, out_ready;
   logic [GENE_W-1:0] in_gene;
   logic [FIT_W-1:0]  in_fit;

   logic              in_ready, out_valid, out_last, done;
   logic [GENE_W-1:0] out_gene;
   logic [FIT_W-1:0]  out_fit;
   logic [IDX_W-1:0]  out_idx;
   logic [RW-1:0]     out_rank;

   logic              in_ready1, out_valid1, out_last1, done1;
   logic [GENE_W-1:0] out_gene1;
   logic [FIT_W-1:0]  out_fit1;
   logic [IDX_W-1:0]  out_idx1;
   logic [RW-1:0]     out_rank1;

   pop_topk_selector #(.GENE_W(GENE_W), .FIT_W(FIT_W), .K(K), .IDX_W(IDX_W), .MAXIMIZE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
      .in_gene(in_gene), .in_fit(in_fit), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_gene(out_gene), .out_fit(out_fit), .out_idx(out_idx),
      .out_rank(out_rank), .out_last(out_last), .done(done));

   pop_topk_selector #(.GENE_W(GENE_W), .FIT_W(FIT_W), .K(K), .IDX_W(IDX_W), .MAXIMIZE(1'b1)) dut_max (
      .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
      .in_gene(in_gene), .in_fit(in_fit), .in_last(in_last), .out_valid(out_valid1),
      .out_ready(out_ready), .out_gene(out_gene1), .out_fit(out_fit1), .out_idx(out_idx1),
      .out_rank(out_rank1), .out_last(out_last1), .done(done1));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [7:0]       pop [8];
   int               pop_n;
   bit               rdy_pat [16];
   int               pat_n;

   logic [7:0]       got_fit [8];
   logic [7:0]       got_gene [8];
   logic [IDX_W-1:0] got_idx [8];
   logic [RW-1:0]    got_rank [8];
   logic             got_last [8];
   logic [7:0]       got_fit1 [8];
   logic [IDX_W-1:0] got_idx1 [8];
   int               n_got;
   logic             done_seen, ov_after;
   int               stall_bad, stall_cnt;

   // Called at a falling edge; start coincides with the caller's current cycle.
   task automatic send_pop();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < pop_n; i++) begin
         in_valid = 1'b1;
         in_fit   = pop[i];
         in_gene  = ~pop[i];
         in_last  = (i == pop_n - 1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Drains the output stream following rdy_pat, recording each handshaken entry.
   task automatic collect();
      logic [7:0] hf, hg;
      logic [IDX_W-1:0] hi;
      bit held;
      n_got = 0; done_seen = 1'b0; ov_after = 1'b1;
      stall_bad = 0; stall_cnt = 0; held = 1'b0;
      hf = '0; hg = '0; hi = '0;
      for (int c = 0; c < 40; c++) begin
         out_ready = (c < pat_n) ? rdy_pat[c] : 1'b1;
         if (out_valid) begin
            if (held && (out_fit !== hf || out_gene !== hg || out_idx !== hi)) stall_bad++;
            held = 1'b0;
            if (out_ready) begin
               if (n_got < 8) begin
                  got_fit[n_got]  = out_fit;
                  got_gene[n_got] = out_gene;
                  got_idx[n_got]  = out_idx;
                  got_rank[n_got] = out_rank;
                  got_last[n_got] = out_last;
                  got_fit1[n_got] = out_fit1;
                  got_idx1[n_got] = out_idx1;
               end
               n_got++;
               if (out_last) begin
                  @(negedge clk);
                  done_seen = done;
                  ov_after  = out_valid;
                  out_ready = 1'b0;
                  return;
               end
            end else begin
               held = 1'b1; hf = out_fit; hg = out_gene; hi = out_idx;
               stall_cnt++;
            end
         end
         @(negedge clk);
      end
      out_ready = 1'b0;
   endtask

   task automatic load_pop1();
      pop[0] = 8'd50; pop[1] = 8'd20; pop[2] = 8'd80;
      pop[3] = 8'd10; pop[4] = 8'd30; pop[5] = 8'd60;
      pop_n = 6;
   endtask

   task automatic test_reset();
      checks++;
      if ({in_ready, out_valid, out_last, done, out_gene, out_fit, out_idx, out_rank} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got %h exp 0",
                  {in_ready, out_valid, out_last, done, out_gene, out_fit, out_idx, out_rank});
      end
   endtask

   task automatic test_basic();
      logic [7:0] ef [4];
      logic [IDX_W-1:0] ei [4];
      ef[0] = 8'd10; ef[1] = 8'd20; ef[2] = 8'd30; ef[3] = 8'd50;
      ei[0] = 4'd3;  ei[1] = 4'd1;  ei[2] = 4'd4;  ei[3] = 4'd0;
      load_pop1(); pat_n = 0;
      send_pop();
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency out_valid %b exp 1", out_valid); end
      collect();
      checks++;
      if (n_got != 4) begin errors++; $display("FAIL basic_count got %0d exp 4", n_got); end
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (got_fit[r] !== ef[r] || got_idx[r] !== ei[r] || got_gene[r] !== ~ef[r] ||
             got_rank[r] !== RW'(r) || got_last[r] !== (r == 3)) begin
            errors++;
            $display("FAIL basic_entry[%0d] fit %0d idx %0d gene %h rank %0d last %b exp fit %0d idx %0d gene %h rank %0d last %b",
                     r, got_fit[r], got_idx[r], got_gene[r], got_rank[r], got_last[r],
                     ef[r], ei[r], ~ef[r], r, (r == 3));
         end
      end
      checks++;
      if (done_seen !== 1'b1 || ov_after !== 1'b0) begin
         errors++; $display("FAIL basic_done done %b out_valid %b exp 1 0", done_seen, ov_after);
      end
   endtask

   task automatic test_ties();
      for (int i = 0; i < 5; i++) pop[i] = 8'd5;
      pop_n = 5; pat_n = 0;
      send_pop();
      collect();
      checks++;
      if (n_got != 4) begin errors++; $display("FAIL ties_count got %0d exp 4", n_got); end
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (got_idx[r] !== IDX_W'(r) || got_fit[r] !== 8'd5) begin
            errors++; $display("FAIL ties_entry[%0d] idx %0d fit %0d exp idx %0d fit 5", r, got_idx[r], got_fit[r], r);
         end
      end
   endtask

   task automatic test_short();
      pop[0] = 8'd9; pop[1] = 8'd7; pop_n = 2; pat_n = 0;
      send_pop();
      collect();
      checks++;
      if (n_got != 2) begin errors++; $display("FAIL short_count got %0d exp 2", n_got); end
      checks++;
      if (got_fit[0] !== 8'd7 || got_idx[0] !== 4'd1 || got_last[0] !== 1'b0) begin
         errors++; $display("FAIL short_rank0 fit %0d idx %0d last %b exp 7 1 0", got_fit[0], got_idx[0], got_last[0]);
      end
      checks++;
      if (got_fit[1] !== 8'd9 || got_idx[1] !== 4'd0 || got_last[1] !== 1'b1) begin
         errors++; $display("FAIL short_rank1 fit %0d idx %0d last %b exp 9 0 1", got_fit[1], got_idx[1], got_last[1]);
      end
      checks++;
      if (done_seen !== 1'b1) begin errors++; $display("FAIL short_done got %b exp 1", done_seen); end
   endtask

   task automatic test_backpressure();
      logic [7:0] ef [4];
      ef[0] = 8'd10; ef[1] = 8'd20; ef[2] = 8'd30; ef[3] = 8'd50;
      rdy_pat[0] = 0; rdy_pat[1] = 0; rdy_pat[2] = 1; rdy_pat[3] = 0;
      rdy_pat[4] = 1; rdy_pat[5] = 1; rdy_pat[6] = 1; pat_n = 7;
      load_pop1();
      send_pop();
      collect();
      checks++;
      if (stall_cnt != 3 || stall_bad != 0) begin
         errors++; $display("FAIL bp_stall stalls %0d unstable %0d exp 3 0", stall_cnt, stall_bad);
      end
      checks++;
      if (n_got != 4) begin errors++; $display("FAIL bp_count got %0d exp 4", n_got); end
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (got_fit[r] !== ef[r] || got_rank[r] !== RW'(r)) begin
            errors++; $display("FAIL bp_entry[%0d] fit %0d rank %0d exp %0d %0d", r, got_fit[r], got_rank[r], ef[r], r);
         end
      end
      checks++;
      if (done_seen !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", done_seen); end
      pat_n = 0;
   endtask

   task automatic test_maximize();
      logic [7:0] ef [4];
      logic [IDX_W-1:0] ei [4];
      ef[0] = 8'd80; ef[1] = 8'd60; ef[2] = 8'd50; ef[3] = 8'd30;
      ei[0] = 4'd2;  ei[1] = 4'd5;  ei[2] = 4'd0;  ei[3] = 4'd4;
      load_pop1(); pat_n = 0;
      send_pop();
      collect();
      for (int r = 0; r < 4; r++) begin
         checks++;
         if (got_fit1[r] !== ef[r] || got_idx1[r] !== ei[r]) begin
            errors++; $display("FAIL max_entry[%0d] fit %0d idx %0d exp %0d %0d", r, got_fit1[r], got_idx1[r], ef[r], ei[r]);
         end
      end
   endtask

   task automatic test_resets();
      // Reset mid-COLLECT
      start = 1'b1; @(negedge clk); start = 1'b0;
      in_valid = 1'b1; in_fit = 8'd11; in_gene = 8'h11; @(negedge clk);
      in_fit = 8'd12; @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_collect_pre in_ready %b exp 1", in_ready); end
      rst_n = 1'b0; #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_collect in_ready %b out_valid %b exp 0 0", in_ready, out_valid);
      end
      in_valid = 1'b0;
      @(negedge clk); rst_n = 1'b1; @(negedge clk);
      // start during EMIT must be ignored, then reset mid-EMIT
      load_pop1(); out_ready = 1'b0;
      send_pop();
      start = 1'b1; @(negedge clk); start = 1'b0; @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_rank !== '0 || out_fit !== 8'd10) begin
         errors++; $display("FAIL emit_start_ignored valid %b ready %b rank %0d fit %0d exp 1 0 0 10",
                            out_valid, in_ready, out_rank, out_fit);
      end
      #2 rst_n = 1'b0; #1;
      checks++;
      if ({in_ready, out_valid, out_last, done, out_gene, out_fit, out_idx, out_rank} !== '0) begin
         errors++; $display("FAIL rst_emit got %h exp 0",
                            {in_ready, out_valid, out_last, done, out_gene, out_fit, out_idx, out_rank});
      end
      @(negedge clk); rst_n = 1'b1; @(negedge clk); @(negedge clk);
      checks++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL rst_no_done done %b out_valid %b exp 0 0", done, out_valid);
      end
      // Fresh round after reset
      load_pop1(); pat_n = 0;
      send_pop();
      collect();
      checks++;
      if (n_got != 4 || got_fit[0] !== 8'd10 || got_fit[3] !== 8'd50 || got_idx[2] !== 4'd4 || done_seen !== 1'b1) begin
         errors++; $display("FAIL rst_fresh n %0d fit0 %0d fit3 %0d idx2 %0d done %b exp 4 10 50 4 1",
                            n_got, got_fit[0], got_fit[3], got_idx[2], done_seen);
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
      in_gene = '0; in_fit = '0; pop_n = 0; pat_n = 0;
      #3;
      test_reset();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_basic();
      test_ties();        // start issued in the done cycle of the previous round
      test_short();
      test_backpressure();
      test_maximize();
      test_resets();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
